pulse_count_uart_tx: RTL and testbench

- Drains 32-bit packed-BCD photon-count words from the count FIFO, whose write side is filled by the pulse-counter adapter once per 50 Hz gate.
- Sends each word over a UART 8N1 line as ASCII decimal text terminated by CR LF.
- Sits between the count FIFO read port and the board TX pin, so the host can log counts without the TFT path.

---
 rtl/pulse_count_uart_tx.sv | 136 +++++++++++++
 tb/tb_pulse_count_uart_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_count_uart_tx.sv
// Streams packed-BCD count words from a FIFO out of a UART 8N1 line as ASCII decimal + CR LF.
// Build option: define PULSE_TX_LZ_SUPPRESS_EN to drop leading '0' digits.
module pulse_count_uart_tx #(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        fifo_is_empty,
  output logic        rd_fifo,
  input  logic [31:0] din,
  output logic        tx,
  output logic        busy,
  output logic        bcd_err
);

  typedef enum logic [1:0] {StIdle, StWait, StLoad, StSend} state_e;

  localparam logic [15:0] BaudLast = 16'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [9:0]  shreg_q, shreg_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] baud_q, baud_d;
  logic        bcd_err_q, bcd_err_d;

  logic [2:0]  dsel;
  logic [3:0]  nib;
  logic [7:0]  char_sel;

`ifdef PULSE_TX_LZ_SUPPRESS_EN
  // Index of the first nonzero digit (MSB-first); an all-zero word still sends digit 7.
  function automatic logic [3:0] first_digit(input logic [31:0] w);
    logic [3:0] r;
    r = 4'd7;
    for (int i = 7; i >= 0; i--) begin
      if (w[4*(7-i) +: 4] != 4'd0) r = 4'(i);
    end
    return r;
  endfunction
`endif

  assign dsel = 3'd7 - idx_q[2:0];
  assign nib  = word_q[{dsel, 2'b00} +: 4];

  always_comb begin
    char_sel = 8'h3F;
    if (idx_q == 4'd8)      char_sel = 8'h0D;
    else if (idx_q == 4'd9) char_sel = 8'h0A;
    else if (nib <= 4'd9)   char_sel = {4'h3, nib};
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    baud_d    = baud_q;
    bcd_err_d = bcd_err_q;
    rd_fifo   = 1'b0;
    case (state_q)
      StIdle: begin
        if (en && !fifo_is_empty) begin
          rd_fifo = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        word_d  = din;
`ifdef PULSE_TX_LZ_SUPPRESS_EN
        idx_d   = first_digit(din);
`else
        idx_d   = 4'd0;
`endif
        state_d = StLoad;
      end
      StLoad: begin
        shreg_d   = {1'b1, char_sel, 1'b0};
        bit_cnt_d = 4'd0;
        baud_d    = 16'd0;
        if (idx_q < 4'd8 && nib > 4'd9) bcd_err_d = 1'b1;
        state_d   = StSend;
      end
      StSend: begin
        if (baud_q == BaudLast) begin
          baud_d  = 16'd0;
          shreg_d = {1'b1, shreg_q[9:1]};
          if (bit_cnt_q == 4'd9) begin
            bit_cnt_d = 4'd0;
            if (idx_q == 4'd9) begin
              idx_d   = 4'd0;
              state_d = StIdle;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = StLoad;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      word_q    <= 32'd0;
      shreg_q   <= 10'h3FF;
      bit_cnt_q <= 4'd0;
      idx_q     <= 4'd0;
      baud_q    <= 16'd0;
      bcd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      baud_q    <= baud_d;
      bcd_err_q <= bcd_err_d;
    end
  end

  // Line is only driven from the shift register while a frame is in progress.
  assign tx      = (state_q == StSend) ? shreg_q[0] : 1'b1;
  assign busy    = (state_q != StIdle) || rd_fifo;
  assign bcd_err = bcd_err_q;

endmodule

// File: tb/tb_pulse_count_uart_tx.sv
// Bench for pulse_count_uart_tx: FIFO model, scoreboard of expected bytes, UART receiver.
module tb_pulse_count_uart_tx;

  localparam int B  = 4;
  localparam int CT = 10 * B + 1;

  logic        clk = 1'b0;
  logic        rst_n, en, fifo_is_empty, rd_fifo, tx, busy, bcd_err;
  logic [31:0] din;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_bytes = 0, flushed = 0, rx_bytes = 0;

  logic [31:0] fifo[$];
  logic [7:0]  expq[$];
  int          rd_list[$];

  bit          rx_on = 1'b0;
  int          rx_cnt = 0;
  logic [7:0]  rx_sh;

  pulse_count_uart_tx #(.BAUD_DIV(B)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .fifo_is_empty(fifo_is_empty),
    .rd_fifo      (rd_fifo),
    .din          (din),
    .tx           (tx),
    .busy         (busy),
    .bcd_err      (bcd_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) fifo_is_empty <= (fifo.size() == 0);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic int start_of(input logic [31:0] w);
`ifdef PULSE_TX_LZ_SUPPRESS_EN
    for (int i = 0; i < 8; i++) if (w[4*(7-i) +: 4] != 4'd0) return i;
    return 7;
`else
    return 0;
`endif
  endfunction

  function automatic logic [7:0] ch(input logic [31:0] w, input int i);
    logic [3:0] n;
    if (i == 8) return 8'h0D;
    if (i == 9) return 8'h0A;
    n = w[4*(7-i) +: 4];
    return (n > 4'd9) ? 8'h3F : (8'h30 + {4'h0, n});
  endfunction

  // FIFO read side: one cycle latency, expectations queued when the word is handed over.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_fifo === 1'b1) begin
      chk("rd_when_empty", {31'd0, fifo_is_empty}, 32'd0);
      if (fifo.size() != 0) begin
        din = fifo.pop_front();
        rd_list.push_back(cyc);
        for (int i = start_of(din); i < 10; i++) begin
          expq.push_back(ch(din, i));
          exp_bytes++;
        end
      end
    end
  end

  // Cycle-counting UART receiver, sampling mid-bit.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      rx_on = 1'b0;
      flushed += expq.size();
      expq.delete();
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= B / 2 && (rx_cnt - B / 2) % B == 0) begin
        if ((rx_cnt - B / 2) / B <= 8) begin
          rx_sh[(rx_cnt - B / 2) / B - 1] = tx;
        end else begin
          chk("stop_bit", {31'd0, tx}, 32'd1);
          rx_on = 1'b0;
          rx_bytes++;
          chk("byte_expected", {31'd0, expq.size() != 0}, 32'd1);
          if (expq.size() != 0) chk("rx_byte", {24'd0, rx_sh}, {24'd0, expq.pop_front()});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step(1);
  endtask

  task automatic wait_rd(input int n, output int t);
    int k = 0;
    while (rd_list.size() <= n && k < 2000) begin
      step(1);
      k++;
    end
    chk("rd_timeout", {31'd0, rd_list.size() > n}, 32'd1);
    t = (rd_list.size() > n) ? rd_list[n] : cyc;
  endtask

  task automatic drain();
    int k = 0;
    while ((fifo.size() != 0 || busy !== 1'b0) && k < 20000) begin
      step(1);
      k++;
    end
    chk("drain_timeout", {31'd0, k < 20000}, 32'd1);
  endtask

  initial begin
    int t, t2, c, n, line, p;
    logic [31:0] w;
    rst_n = 1'b0; en = 1'b0; din = 32'd0; fifo_is_empty = 1'b1;
    step(3);
    chk("rst_rd_fifo", {31'd0, rd_fifo}, 32'd0);
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bcd_err", {31'd0, bcd_err}, 32'd0);
    rst_n = 1'b1;
    step(2);

    // Single word: latency, line time, busy fall, no extra pop.
    w = 32'h00012345;
    fifo.push_back(w); en = 1'b1;
    wait_rd(0, t);
    line = (10 - start_of(w)) * CT;
    goto(t + 1); chk("busy_after_pop", {31'd0, busy}, 32'd1);
    chk("tx_wait", {31'd0, tx}, 32'd1);
    goto(t + 2); chk("tx_load", {31'd0, tx}, 32'd1);
    goto(t + 3); chk("tx_start", {31'd0, tx}, 32'd0);
    goto(t + 1 + line); chk("busy_last_stop", {31'd0, busy}, 32'd1);
    chk("tx_last_stop", {31'd0, tx}, 32'd1);
    goto(t + 2 + line); chk("busy_fall", {31'd0, busy}, 32'd0);
    step(20);
    chk("single_pop", rd_list.size(), 1);
    chk("bcd_err_clean", {31'd0, bcd_err}, 32'd0);

    // Back-to-back words.
    fifo.push_back(32'h99999999); fifo.push_back(32'h00000000);
    wait_rd(1, t);
    wait_rd(2, t2);
    chk("b2b_gap", t2, t + 2 + (10 - start_of(32'h99999999)) * CT);
    drain();

    // Invalid nibble sets sticky error exactly at the '?' load.
    w = 32'h0000A001;
    fifo.push_back(w);
    wait_rd(3, t);
    p = 4 - start_of(w);
    goto(t + 2 + p * CT); chk("err_before_q", {31'd0, bcd_err}, 32'd0);
    step(1); chk("err_after_q", {31'd0, bcd_err}, 32'd1);
    drain();
    fifo.push_back(32'h00000005);
    drain();
    chk("err_sticky", {31'd0, bcd_err}, 32'd1);

    // en dropped during the third character.
    n = rd_list.size();
    fifo.push_back(32'h11112222); fifo.push_back(32'h33334444); fifo.push_back(32'h55556666);
    wait_rd(n, t);
    goto(t + 2 + 2 * CT + 5);
    en = 1'b0;
    c = 0;
    while (busy !== 1'b0 && c < 2000) begin step(1); c++; end
    chk("en_low_finish", {31'd0, busy}, 32'd0);
    step(30);
    chk("no_pop_en_low", rd_list.size(), n + 1);
    chk("rd_low_en_low", {31'd0, rd_fifo}, 32'd0);
    en = 1'b1;
    c = cyc;
    wait_rd(n + 1, t);
    chk("pop_on_en", t, c);
    drain();

    // Reset during data bits of the fifth character.
    n = rd_list.size();
    fifo.push_back(32'h00012345);
    wait_rd(n, t);
    goto(t + 2 + 4 * CT + B + 3);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("rst_mid_tx", {31'd0, tx}, 32'd1);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_rd", {31'd0, rd_fifo}, 32'd0);
    fifo.push_back(32'h00000077);
    wait_rd(n + 1, t);
    drain();

    // Leading-zero words (all digits in the default build).
    fifo.push_back(32'h00001234); fifo.push_back(32'h00000000);
    drain();
    step(10);

    chk("sb_empty", expq.size(), 0);
    chk("rx_count", rx_bytes, exp_bytes - flushed);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
